// File: rtl/serial_magnitude_comparator_pkg.sv
// Package shared by the bit-serial magnitude comparator.
// Provides the controller state encoding and a helper that sizes the
// bit-index counter so a single-bit operand still gets a 1-bit counter.
package serial_magnitude_comparator_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  // Width of a counter that must hold values 0..w-1 (never less than 1 bit).
  function automatic int idx_width(input int w);
    if (w > 1) begin
      return $clog2(w);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/serial_magnitude_comparator_cell.sv
// one_bit_comparator: combinational single-bit magnitude comparator cell.
// Ports:
//   g : out, a > b
//   e : out, a == b
//   l : out, a < b
//   a : in,  operand bit A
//   b : in,  operand bit B
module one_bit_comparator (
  output logic g,
  output logic e,
  output logic l,
  input  logic a,
  input  logic b
);

  assign g = a & ~b;
  assign e = ~(a ^ b);
  assign l = ~a & b;

endmodule

// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator: compares two WIDTH-bit operands one bit pair
// per clock, MSB first, through a single one_bit_comparator cell. Stops at
// the first unequal bit and reports greater/equal/less with a done pulse.
// Ports:
//   clk    : in,  rising-edge clock
//   rst_n  : in,  synchronous active-low reset
//   start  : in,  compare request, only honoured in IDLE
//   a, b   : in,  WIDTH-bit operands captured with an accepted start
//   busy   : out, high while comparing and during the done cycle
//   done   : out, one-cycle pulse when the result becomes valid
//   g/e/l  : out, A>B / A==B / A<B, held until the next accepted start
//   cycles : out, number of bit pairs examined for the last result
module serial_magnitude_comparator
  import serial_magnitude_comparator_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             g,
  output logic             e,
  output logic             l,
  output logic [CW-1:0]    cycles
);

  localparam int IW = idx_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             g_q, g_d;
  logic             e_q, e_d;
  logic             l_q, l_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic [CW-1:0]    cycles_q, cycles_d;

  logic             cell_g_s;
  logic             cell_e_s;
  logic             cell_l_s;

  // The cell always looks at the current MSBs of the shift registers.
  one_bit_comparator u_cell (
    .g (cell_g_s),
    .e (cell_e_s),
    .l (cell_l_s),
    .a (sa_q[WIDTH-1]),
    .b (sb_q[WIDTH-1])
  );

  // Next-state, datapath and output-register logic for the controller.
  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    idx_d    = idx_q;
    g_d      = g_q;
    e_d      = e_q;
    l_d      = l_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    cycles_d = cycles_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sa_d     = a;
          sb_d     = b;
          idx_d    = IW'(WIDTH - 1);
          g_d      = 1'b0;
          e_d      = 1'b0;
          l_d      = 1'b0;
          cycles_d = '0;
          busy_d   = 1'b1;
          state_d  = S_COMPARE;
        end else begin
          busy_d   = 1'b0;
        end
      end

      S_COMPARE: begin
        busy_d   = 1'b1;
        cycles_d = cycles_q + CW'(1);
        if (!cell_e_s) begin
          // First unequal bit decides the result.
          g_d     = cell_g_s;
          l_d     = cell_l_s;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (idx_q == '0) begin
          // LSB reached with every bit equal.
          e_d     = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          sa_d    = sa_q << 1;
          sb_d    = sb_q << 1;
          idx_d   = idx_q - IW'(1);
        end
      end

      S_DONE: begin
        // done_q drops here; IDLE is always revisited before a new start.
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and register update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      idx_q    <= '0;
      g_q      <= 1'b0;
      e_q      <= 1'b0;
      l_q      <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      idx_q    <= idx_d;
      g_q      <= g_d;
      e_q      <= e_d;
      l_q      <= l_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      cycles_q <= cycles_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign g      = g_q;
  assign e      = e_q;
  assign l      = l_q;
  assign cycles = cycles_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Scoreboard bench for serial_magnitude_comparator (WIDTH=8 and WIDTH=1).
// Drivers push the expected result and the cycle at which done must appear;
// per-DUT monitors pop and compare whenever done is seen.
module tb_serial_magnitude_comparator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, start1;
  logic [7:0] a8, b8;
  logic [0:0] a1, b1;
  logic       busy8, done8, g8, e8, l8;
  logic [3:0] cycles8;
  logic       busy1, done1, g1, e1, l1;
  logic [0:0] cycles1;

  typedef struct {
    int g;
    int e;
    int l;
    int m;
    int t;
  } exp_t;

  exp_t q8[$];
  exp_t q1[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  serial_magnitude_comparator #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .g(g8), .e(e8), .l(l8), .cycles(cycles8)
  );

  serial_magnitude_comparator #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .g(g1), .e(e1), .l(l1), .cycles(cycles1)
  );

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Bit pairs examined: position of first differing bit from the MSB, or 8.
  function automatic int lead_m(input logic [7:0] x, input logic [7:0] y);
    for (int i = 7; i >= 0; i--) begin
      if (x[i] != y[i]) return 8 - i;
    end
    return 8;
  endfunction

  // Monitor for the 8-bit DUT.
  always @(negedge clk) begin
    exp_t x;
    if (done8) begin
      if (q8.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done8: got done=1, expected none (cycle %0d)", cyc);
      end else begin
        x = q8.pop_front();
        check("g8", g8, x.g);
        check("e8", e8, x.e);
        check("l8", l8, x.l);
        check("cycles8", cycles8, x.m);
        check("latency8", cyc, x.t);
      end
    end
  end

  // Monitor for the 1-bit DUT.
  always @(negedge clk) begin
    exp_t x;
    if (done1) begin
      if (q1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done1: got done=1, expected none (cycle %0d)", cyc);
      end else begin
        x = q1.pop_front();
        check("g1", g1, x.g);
        check("e1", e1, x.e);
        check("l1", l1, x.l);
        check("cycles1", cycles1, x.m);
        check("latency1", cyc, x.t);
      end
    end
  end

  task automatic wait_idle8();
    int n = 0;
    while (busy8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy8) begin
      total++;
      bad++;
      $display("FAIL idle_timeout8: got busy=1, expected 0 within 40 cycles");
    end
  endtask

  // Called at a negedge: start is seen at the next edge (E0).
  task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input bit push,
                        input int eg, input int ee, input int el, input int em);
    wait_idle8();
    a8 = av;
    b8 = bv;
    start8 = 1'b1;
    if (push) q8.push_back('{eg, ee, el, em, cyc + 1 + em});
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic issue8_model(input logic [7:0] av, input logic [7:0] bv);
    issue8(av, bv, 1'b1, int'(av > bv), int'(av == bv), int'(av < bv), lead_m(av, bv));
  endtask

  task automatic issue1(input logic av, input logic bv, input int eg, input int ee, input int el);
    int n = 0;
    while (busy1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    a1 = av;
    b1 = bv;
    start1 = 1'b1;
    q1.push_back('{eg, ee, el, 1, cyc + 2});
    @(negedge clk);
    start1 = 1'b0;
  endtask

  task automatic check_zero8(input string tag);
    check({tag, "_busy"}, busy8, 0);
    check({tag, "_done"}, done8, 0);
    check({tag, "_g"}, g8, 0);
    check({tag, "_e"}, e8, 0);
    check({tag, "_l"}, l8, 0);
    check({tag, "_cycles"}, cycles8, 0);
  endtask

  initial begin
    int k;
    int n;
    logic [7:0] av;
    logic [7:0] bv;

    rst_n  = 1'b0;
    start8 = 1'b0;
    start1 = 1'b0;
    a8 = 8'h00;
    b8 = 8'h00;
    a1 = 1'b0;
    b1 = 1'b0;
    repeat (3) @(negedge clk);
    check_zero8("reset");
    check("reset_busy1", busy1, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // WIDTH=1: all four pairs, each completes on COMPARE's first edge.
    issue1(1'b0, 1'b0, 0, 1, 0);
    issue1(1'b0, 1'b1, 0, 0, 1);
    issue1(1'b1, 1'b0, 1, 0, 0);
    issue1(1'b1, 1'b1, 0, 1, 0);

    // Directed WIDTH=8 vectors.
    issue8(8'hA5, 8'h25, 1'b1, 1, 0, 0, 1);
    issue8(8'h3C, 8'h3D, 1'b1, 0, 0, 1, 8);

    // Equal operands; A changes after acceptance and must have no effect.
    issue8(8'h5A, 8'h5A, 1'b1, 0, 1, 0, 8);
    a8 = 8'hFF;

    // Start pulses during COMPARE and on the DONE cycle are ignored.
    issue8(8'h3C, 8'h3D, 1'b1, 0, 0, 1, 8);
    repeat (2) @(negedge clk);
    start8 = 1'b1;
    a8 = 8'h00;
    @(negedge clk);
    start8 = 1'b0;
    repeat (5) @(negedge clk);
    check("done_cycle_seen", done8, 1);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;

    // Start held high: back-to-back compares, one IDLE cycle between (m=2).
    wait_idle8();
    k = cyc;
    a8 = 8'hC0;
    b8 = 8'h80;
    start8 = 1'b1;
    for (int i = 0; i < 3; i++) q8.push_back('{1, 0, 0, 2, k + 3 + i * 4});
    repeat (9) @(negedge clk);
    start8 = 1'b0;

    // Reset three cycles into a compare: abandoned, no done, outputs cleared.
    issue8(8'h01, 8'h00, 1'b0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_zero8("midreset");
    rst_n = 1'b1;
    issue8(8'h01, 8'h00, 1'b1, 1, 0, 0, 8);

    // Boundary pairs.
    issue8_model(8'h00, 8'hFF);
    issue8_model(8'hFF, 8'h00);
    issue8_model(8'h00, 8'h00);
    issue8_model(8'hFF, 8'hFF);
    issue8_model(8'hFE, 8'hFF);

    // Every first-difference position, both polarities, plus equality.
    for (int i = 0; i < 12; i++) begin
      av = 8'($urandom);
      for (int j = 0; j <= 8; j++) begin
        bv = (j < 8) ? (av ^ (8'h80 >> j)) : av;
        issue8_model(av, bv);
      end
    end

    // Random pairs.
    for (int i = 0; i < 60; i++) begin
      issue8_model(8'($urandom), 8'($urandom));
    end

    // Drain both scoreboards, then idle to catch any spurious done.
    n = 0;
    while ((q8.size() != 0 || q1.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_q8", q8.size(), 0);
    check("drain_q1", q1.size(), 0);
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
